// File: rtl/pcpi_initiator.sv
// pcpi_initiator
//   Hands a custom instruction from the core to a PicoRV32-style PCPI
//   coprocessor bus. It then returns the result, or an illegal-instruction
//   trap, to the core.
//
//   Flow: IDLE (accept a request) -> ISSUE (hold pcpi_valid until a
//   coprocessor answers, flush arrives or the claim timeout expires) ->
//   RESP (hold the response until the core takes it) -> IDLE.
//
// Ports
//   clk, resetn                      clock, asynchronous active-low reset
//   req_valid/req_ready              request handshake from the core
//   req_insn/req_rs1/req_rs2         instruction word and operands
//   flush                            abandon the outstanding request (ISSUE only)
//   pcpi_valid/insn/rs1/rs2          request presented to the coprocessors
//   pcpi_wr/rd/wait/ready            coprocessor answer
//   rsp_valid/rsp_ready              response handshake to the core
//   rsp_rd/rsp_wr/rsp_trap           result, write-enable, illegal-instruction flag
module pcpi_initiator #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_insn,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic        flush,
  output logic        pcpi_valid,
  output logic [31:0] pcpi_insn,
  output logic [31:0] pcpi_rs1,
  output logic [31:0] pcpi_rs2,
  input  logic        pcpi_wr,
  input  logic [31:0] pcpi_rd,
  input  logic        pcpi_wait,
  input  logic        pcpi_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rd,
  output logic        rsp_wr,
  output logic        rsp_trap
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  // The counter reaches zero TIMEOUT_CYCLES-1 cycles after pcpi_valid rises.
  // The trap is taken on the following edge, so it lands exactly
  // TIMEOUT_CYCLES cycles after pcpi_valid rises.
  localparam logic [7:0] TO_LOAD = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]  r_state;
  logic [7:0]  r_cnt;
  logic        r_pcpi_valid;
  logic [31:0] r_pcpi_insn;
  logic [31:0] r_pcpi_rs1;
  logic [31:0] r_pcpi_rs2;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rd;
  logic        r_rsp_wr;
  logic        r_rsp_trap;

  logic        w_accept;

  assign req_ready = (r_state == ST_IDLE);
  assign w_accept  = req_valid && req_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 8'd0;
      r_pcpi_valid <= 1'b0;
      r_pcpi_insn  <= 32'd0;
      r_pcpi_rs1   <= 32'd0;
      r_pcpi_rs2   <= 32'd0;
      r_rsp_valid  <= 1'b0;
      r_rsp_rd     <= 32'd0;
      r_rsp_wr     <= 1'b0;
      r_rsp_trap   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Issue stage boundary: request fields are frozen onto the PCPI bus.
          if (w_accept) begin
            r_pcpi_insn  <= req_insn;
            r_pcpi_rs1   <= req_rs1;
            r_pcpi_rs2   <= req_rs2;
            r_pcpi_valid <= 1'b1;
            r_cnt        <= TO_LOAD;
            r_state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Priority: flush > ready > wait > timeout countdown.
          // pcpi_valid drops on every exit, so a coprocessor that answered
          // never sees the instruction a second time.
          if (flush) begin
            r_pcpi_valid <= 1'b0;
            r_state      <= ST_IDLE;
          end else if (pcpi_ready) begin
            r_rsp_rd     <= pcpi_rd;
            r_rsp_wr     <= pcpi_wr;
            r_rsp_trap   <= 1'b0;
            r_rsp_valid  <= 1'b1;
            r_pcpi_valid <= 1'b0;
            r_state      <= ST_RESP;
          end else if (pcpi_wait) begin
            // A claimed instruction may stay busy indefinitely.
            r_cnt <= TO_LOAD;
          end else if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
          end else begin
            // Nobody claimed the instruction: report it as illegal.
            r_rsp_rd     <= 32'd0;
            r_rsp_wr     <= 1'b0;
            r_rsp_trap   <= 1'b1;
            r_rsp_valid  <= 1'b1;
            r_pcpi_valid <= 1'b0;
            r_state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          // Response stage boundary: hold until the core consumes it.
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_pcpi_valid <= 1'b0;
          r_rsp_valid  <= 1'b0;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

  assign pcpi_valid = r_pcpi_valid;
  assign pcpi_insn  = r_pcpi_insn;
  assign pcpi_rs1   = r_pcpi_rs1;
  assign pcpi_rs2   = r_pcpi_rs2;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_rd     = r_rsp_rd;
  assign rsp_wr     = r_rsp_wr;
  assign rsp_trap   = r_rsp_trap;

endmodule
